// File: rtl/srl_fifo_pkg.sv
// Shared address/level types for SRL-backed FIFO control logic.
package srl_fifo_pkg;
  localparam int unsigned SRL_AW        = 6;
  localparam int unsigned SRL_MAX_DEPTH = 64;
  localparam int unsigned SRL_LW        = SRL_AW + 1;

  typedef logic [SRL_AW-1:0] srl_addr_t;
  typedef logic [SRL_LW-1:0] srl_lvl_t;
endpackage

// File: rtl/srl_fifo_level.sv
// Occupancy tracker: SRL entry count, read address of the oldest entry,
// total level (including any output register) and almost-full flag.
module srl_fifo_level
  import srl_fifo_pkg::*;
#(
  parameter int unsigned AFULL = 56
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      spop,
  input  logic      hold_nxt,
  output srl_lvl_t  cnt,
  output srl_addr_t srl_a,
  output srl_lvl_t  level,
  output logic      afull
);

  srl_lvl_t  cnt_nxt;
  srl_addr_t addr_nxt;
  srl_lvl_t  lvl_nxt;
  logic      afull_nxt;

  // Address is derived from the next count so it never sees a wrapped value.
  always_comb begin
    cnt_nxt = cnt;
    if (push && !spop) begin
      cnt_nxt = cnt + srl_lvl_t'(1);
    end else if (spop && !push) begin
      cnt_nxt = cnt - srl_lvl_t'(1);
    end
    addr_nxt  = (cnt_nxt == '0) ? '0 : SRL_AW'(cnt_nxt - srl_lvl_t'(1));
    lvl_nxt   = cnt_nxt + srl_lvl_t'(hold_nxt);
    afull_nxt = (lvl_nxt >= srl_lvl_t'(AFULL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      srl_a <= '0;
      level <= '0;
      afull <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      srl_a <= addr_nxt;
      level <= lvl_nxt;
      afull <= afull_nxt;
    end
  end

endmodule

// File: rtl/srl64_fifo_ctl.sv
// Valid/ready FIFO sequencer around an external 64-entry addressable SRL.
// Define SRLFIFO_OREG_EN to add an output register (capacity DEPTH+1).
module srl64_fifo_ctl
  import srl_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AFULL = 56
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] srl_d,
  output logic             srl_ce,
  output srl_addr_t        srl_a,
  input  logic [WIDTH-1:0] srl_y,
  output srl_lvl_t         level,
  output logic             afull
);

  logic     push;
  logic     spop;
  logic     hold_nxt;
  srl_lvl_t cnt;

  // No write-through: a full SRL blocks the write even if the head leaves.
  assign in_ready = (cnt != srl_lvl_t'(DEPTH));
  assign push     = in_valid & in_ready;
  assign srl_d    = in_data;
  assign srl_ce   = push;

`ifdef SRLFIFO_OREG_EN
  logic             ov;
  logic             load;
  logic [WIDTH-1:0] oreg;

  // Refill the output register whenever it is empty or being consumed.
  assign load = (cnt != '0) & (~ov | out_ready);
  assign spop = load;

  always_comb begin
    hold_nxt = ov;
    if (load) begin
      hold_nxt = 1'b1;
    end else if (out_ready && ov) begin
      hold_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ov   <= 1'b0;
      oreg <= '0;
    end else begin
      ov <= hold_nxt;
      if (load) begin
        oreg <= srl_y;
      end
    end
  end

  assign out_valid = ov;
  assign out_data  = oreg;
`else
  assign out_valid = (cnt != '0);
  assign out_data  = srl_y;
  assign spop      = out_valid & out_ready;
  assign hold_nxt  = 1'b0;
`endif

  srl_fifo_level #(
    .AFULL(AFULL)
  ) u_level (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .spop    (spop),
    .hold_nxt(hold_nxt),
    .cnt     (cnt),
    .srl_a   (srl_a),
    .level   (level),
    .afull   (afull)
  );

endmodule

// File: tb/tb_srl64_fifo_ctl.sv
// Directed bench for srl64_fifo_ctl with a behavioural 64x12 SRL model.
module tb_srl64_fifo_ctl;
  localparam int WIDTH = 12;
  localparam int AFULL = 56;
`ifdef SRLFIFO_OREG_EN
  localparam int CAP = 65;
`else
  localparam int CAP = 64;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] srl_d;
  logic             srl_ce;
  logic [5:0]       srl_a;
  logic [WIDTH-1:0] srl_y;
  logic [6:0]       level;
  logic             afull;

  logic [WIDTH-1:0] mem [64];
  logic [WIDTH-1:0] q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Addressable shift register: new word enters at 0, oldest sits at cnt-1.
  always @(posedge clk) begin
    if (srl_ce) begin
      for (int i = 63; i > 0; i--) mem[i] <= mem[i-1];
      mem[0] <= srl_d;
    end
  end
  assign srl_y = mem[srl_a];

  srl64_fifo_ctl #(.WIDTH(WIDTH), .DEPTH(64), .AFULL(AFULL)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .srl_d    (srl_d),
    .srl_ce   (srl_ce),
    .srl_a    (srl_a),
    .srl_y    (srl_y),
    .level    (level),
    .afull    (afull)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; the queue is the reference FIFO.
  task automatic cyc(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
    logic acc;
    logic pop;
    int   sz;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(q.size() < CAP));
`ifndef SRLFIFO_OREG_EN
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
`endif
    pop = out_valid && ordy;
    if (pop && q.size() > 0) chk("out_data", 32'(out_data), 32'(q[0]));
    acc = iv && (q.size() < CAP);
    @(posedge clk);
    #1;
    if (pop && q.size() > 0) void'(q.pop_front());
    if (acc) q.push_back(d);
    sz = q.size();
    chk("level", 32'(level), 32'(sz));
    chk("afull", 32'(afull), 32'(sz >= AFULL));
`ifdef SRLFIFO_OREG_EN
    sz = sz - int'(out_valid);
`endif
    chk("srl_a", 32'(srl_a), 32'((sz == 0) ? 0 : sz - 1));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() > 0; i++) cyc(1'b0, '0, 1'b1);
    chk("drained_level", 32'(level), 32'd0);
  endtask

  initial begin
    int words;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_srl_a", 32'(srl_a), 32'd0);
    chk("rst_afull", 32'(afull), 32'd0);

    // Single word, consumer stalled.
    cyc(1'b1, 12'h123, 1'b0);
`ifdef SRLFIFO_OREG_EN
    chk("t1_ov_lat", 32'(out_valid), 32'd0);
    cyc(1'b0, '0, 1'b0);
`endif
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_data", 32'(out_data), 32'h123);
    chk("t1_level", 32'(level), 32'd1);
    cyc(1'b0, '0, 1'b1);
    chk("t1_empty", 32'(out_valid), 32'd0);

    // Fill to capacity, try one more, then drain in order.
    for (int i = 0; i < CAP; i++) cyc(1'b1, WIDTH'(i), 1'b0);
    chk("t2_full_ready", 32'(in_ready), 32'd0);
    chk("t2_full_afull", 32'(afull), 32'd1);
    cyc(1'b1, 12'hFFF, 1'b0);
    chk("t2_blocked_level", 32'(level), 32'(CAP));
    for (int i = 0; i < CAP; i++) begin
      chk("t2_order", 32'(out_data), 32'(i));
      cyc(1'b0, '0, 1'b1);
    end
    chk("t2_empty", 32'(out_valid), 32'd0);

    // Steady push+pop at level 10.
    for (int i = 0; i < 10; i++) cyc(1'b1, WIDTH'(12'h100 + i), 1'b0);
    for (int k = 0; k < 100; k++) cyc(1'b1, WIDTH'(12'h200 + k), 1'b1);
    chk("t3_level", 32'(level), 32'd10);
`ifdef SRLFIFO_OREG_EN
    chk("t3_srl_a", 32'(srl_a), 32'd8);
`else
    chk("t3_srl_a", 32'(srl_a), 32'd9);
`endif
    drain();

    // Full with both handshakes offered: pop only.
    for (int i = 0; i < CAP; i++) cyc(1'b1, WIDTH'(12'h300 + i), 1'b0);
    cyc(1'b1, 12'h7FF, 1'b1);
    chk("t4_level", 32'(level), 32'(CAP - 1));
    chk("t4_in_ready", 32'(in_ready), 32'd1);
    drain();

    // Reset mid-operation discards everything, including that cycle's handshakes.
    for (int i = 0; i < 30; i++) cyc(1'b1, WIDTH'(12'h400 + i), 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_data = 12'h555; out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_srl_a", 32'(srl_a), 32'd0);
    cyc(1'b1, 12'hABC, 1'b0);
`ifdef SRLFIFO_OREG_EN
    cyc(1'b0, '0, 1'b0);
`endif
    chk("t5_head", 32'(out_data), 32'hABC);
    cyc(1'b0, '0, 1'b1);

    // Random 50% valid/ready traffic.
    words = 0;
`ifdef SRLFIFO_OREG_EN
    for (int c = 0; c < 30000 && words < 10000; c++) begin
`else
    for (int c = 0; c < 3000; c++) begin
`endif
      logic iv;
      iv = 1'($urandom_range(1));
      if (iv && q.size() < CAP) words++;
      cyc(iv, WIDTH'(words), 1'($urandom_range(1)));
      chk("t6_level_bound", 32'(level <= 7'(CAP)), 32'd1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
